// File: rtl/systolic_array_param.sv
// systolic_array_param
// Output-stationary systolic GEMM tile engine with an AR_SIZE x AR_SIZE PE grid.
// Streams one K-deep slice of activations (A, one element per row) and weights
// (B, one element per column) from the tile buffers. The slice is skewed so that
// PE(i,j) sees step k in BUSY cycle k+i+j. The accumulated tile is then written
// to the C buffer one row per cycle.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   enable        start request, sampled in IDLE
//   accumulate    sampled with enable; 1 keeps the previous PE results
//   K             number of k-steps in this slice
//   B_offset      signed offset added to every valid weight
//   A_index/A_data   activation read address / same-cycle row data
//   B_index/B_data   weight read address / same-cycle column data (MSB = valid)
//   C_index/C_data_out/C_wr_en   result row write port
//   busy          enable OR engine not idle (combinational)
//   done          one-cycle pulse in the first IDLE cycle after the last row
module systolic_array_param #(
    parameter int A_BITS   = 8,
    parameter int B_BITS   = 9,
    parameter int A_DEPTH  = 14,
    parameter int B_DEPTH  = 14,
    parameter int C_DEPTH  = 2,
    parameter int AR_SIZE  = 4,
    parameter int ACC_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        accumulate,
    input  logic [15:0]                 K,
    input  logic [31:0]                 B_offset,
    output logic [A_DEPTH-1:0]          A_index,
    input  logic [AR_SIZE*A_BITS-1:0]   A_data,
    output logic [B_DEPTH-1:0]          B_index,
    input  logic [AR_SIZE*B_BITS-1:0]   B_data,
    output logic [C_DEPTH-1:0]          C_index,
    output logic [AR_SIZE*ACC_BITS-1:0] C_data_out,
    output logic                        C_wr_en,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {IDLE, BUSY, WRITE} state_t;

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic [15:0] k_reg;
    logic        start, busy_last, write_last, feed_on;

    // a_link[i][j] / b_link[i][j] are the operands arriving at PE(i,j) this cycle
    logic [A_BITS-1:0]   a_link [AR_SIZE][AR_SIZE];
    logic [B_BITS-1:0]   b_link [AR_SIZE][AR_SIZE];
    logic [A_BITS-1:0]   a_feed [AR_SIZE];
    logic [B_BITS-1:0]   b_feed [AR_SIZE];
    logic [ACC_BITS-1:0] acc_v  [AR_SIZE][AR_SIZE];

    assign start      = (state == IDLE) && enable;
    assign busy_last  = (cnt == 32'(k_reg) + 32'(2 * AR_SIZE - 2));
    assign write_last = (cnt == 32'(AR_SIZE - 1));
    // Past step K-1 the edges are fed zeros so the valid flags drain out as 0
    assign feed_on    = (state == BUSY) && (cnt < 32'(k_reg));
    assign busy       = enable || (state != IDLE);

    // Control registers: state, cycle/row counter, latched K and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            k_reg <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= (state == WRITE) && write_last;
            if (start) begin
                k_reg <= K;
            end
        end
    end

    // Next state: BUSY lasts K+2N-1 cycles (feed plus skew fill and drain),
    // WRITE lasts N cycles, one row each
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (busy_last) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            WRITE: begin
                if (write_last) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Buffer addressing and result row output; everything is zero outside BUSY/WRITE
    always_comb begin
        A_index    = '0;
        B_index    = '0;
        C_index    = '0;
        C_wr_en    = 1'b0;
        C_data_out = '0;
        if (state == BUSY) begin
            A_index = cnt[A_DEPTH-1:0];
            B_index = cnt[B_DEPTH-1:0];
        end
        if (state == WRITE) begin
            C_index = cnt[C_DEPTH-1:0];
            C_wr_en = 1'b1;
            for (int r = 0; r < AR_SIZE; r++) begin
                if (C_DEPTH'(r) == cnt[C_DEPTH-1:0]) begin
                    for (int j = 0; j < AR_SIZE; j++) begin
                        C_data_out[j*ACC_BITS +: ACC_BITS] = acc_v[r][j];
                    end
                end
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < AR_SIZE; gi++) begin : g_edge
            assign a_feed[gi] = feed_on ? A_data[gi*A_BITS +: A_BITS] : '0;
            assign b_feed[gi] = feed_on ? B_data[gi*B_BITS +: B_BITS] : '0;

            if (gi == 0) begin : g_noskew
                assign a_link[0][0] = a_feed[0];
                assign b_link[0][0] = b_feed[0];
            end else begin : g_skew
                logic [A_BITS-1:0] a_sr [gi];
                logic [B_BITS-1:0] b_sr [gi];

                // Edge skew: row gi of A and column gi of B are delayed gi cycles
                always_ff @(posedge clk or posedge rst) begin
                    if (rst || start) begin
                        for (int d = 0; d < gi; d++) begin
                            a_sr[d] <= '0;
                            b_sr[d] <= '0;
                        end
                    end else begin
                        a_sr[0] <= a_feed[gi];
                        b_sr[0] <= b_feed[gi];
                        for (int d = 1; d < gi; d++) begin
                            a_sr[d] <= a_sr[d-1];
                            b_sr[d] <= b_sr[d-1];
                        end
                    end
                end

                assign a_link[gi][0] = a_sr[gi-1];
                assign b_link[0][gi] = b_sr[gi-1];
            end
        end

        for (gi = 0; gi < AR_SIZE; gi++) begin : g_row
            for (gj = 0; gj < AR_SIZE; gj++) begin : g_pe
                logic [ACC_BITS-1:0] acc_q;
                logic [ACC_BITS-1:0] a_ext, w_ext, prod;
                logic [A_BITS-1:0]   a_in;
                logic [B_BITS-1:0]   b_in;

                assign a_in  = a_link[gi][gj];
                assign b_in  = b_link[gi][gj];
                assign a_ext = ACC_BITS'($signed(a_in));
                assign w_ext = ACC_BITS'($signed(b_in[B_BITS-2:0])) + ACC_BITS'($signed(B_offset));
                assign prod  = a_ext * w_ext;

                // Accumulate only in BUSY on a valid weight, so PEs stay frozen in WRITE
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        acc_q <= '0;
                    end else if (start) begin
                        if (!accumulate) begin
                            acc_q <= '0;
                        end
                    end else if ((state == BUSY) && b_in[B_BITS-1]) begin
                        acc_q <= acc_q + prod;
                    end
                end

                assign acc_v[gi][gj] = acc_q;

                // Pass-through registers exist only where a neighbour consumes them
                if (gj < AR_SIZE - 1) begin : g_apass
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst || start) begin
                            a_link[gi][gj+1] <= '0;
                        end else begin
                            a_link[gi][gj+1] <= a_in;
                        end
                    end
                end
                if (gi < AR_SIZE - 1) begin : g_bpass
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst || start) begin
                            b_link[gi+1][gj] <= '0;
                        end else begin
                            b_link[gi+1][gj] <= b_in;
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array_param.sv
// tb_systolic_array_param
// Table-driven bench for systolic_array_param (N=4). Each record loads the A/B
// tile buffer models, starts a run, collects the written rows and compares them
// with hand-computed results: C[r][j] = exp_base + exp_rc*(r+1)*(j+1).
// A hand-written sequence covers the reset-during-BUSY abort.
module tb_systolic_array_param;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          accumulate;
    logic [15:0]   K;
    logic [31:0]   B_offset;
    logic [13:0]   A_index;
    logic [31:0]   A_data;
    logic [13:0]   B_index;
    logic [35:0]   B_data;
    logic [1:0]    C_index;
    logic [127:0]  C_data_out;
    logic          C_wr_en;
    logic          busy;
    logic          done;

    logic [31:0]  a_mem [16];
    logic [35:0]  b_mem [16];

    int           total = 0;
    int           bad = 0;
    int           wr_count, first_wr, done_n, done_cnt, busy_low;
    logic         busy_at_done;
    logic [127:0] cap_data [N];
    logic [1:0]   cap_idx  [N];

    typedef struct {
        int          k;
        logic [31:0] off;
        bit          accum;
        logic [7:0]  a0;
        logic [7:0]  a1;
        bit          a_rowinc;
        logic [8:0]  b0;
        logic [8:0]  b1;
        bit          b_colinc;
        logic [31:0] exp_base;
        logic [31:0] exp_rc;
        int          poke;
    } vec_t;

    vec_t vecs [10];

    systolic_array_param #(
        .A_BITS(8), .B_BITS(9), .A_DEPTH(14), .B_DEPTH(14),
        .C_DEPTH(2), .AR_SIZE(N), .ACC_BITS(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .accumulate(accumulate),
        .K(K), .B_offset(B_offset),
        .A_index(A_index), .A_data(A_data),
        .B_index(B_index), .B_data(B_data),
        .C_index(C_index), .C_data_out(C_data_out), .C_wr_en(C_wr_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Tile buffer models: asynchronous reads of the addressed slice
    always_comb begin
        A_data = '0;
        B_data = '0;
        if (A_index < 14'd16) A_data = a_mem[A_index[3:0]];
        if (B_index < 14'd16) B_data = b_mem[B_index[3:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Steps below K come from the record; later addresses hold non-zero valid
    // data that must never be accumulated.
    task automatic loadMem(input vec_t v);
        logic [7:0] av;
        logic [8:0] bv;
        for (int s = 0; s < 16; s++) begin
            for (int i = 0; i < N; i++) begin
                av = (s >= v.k) ? 8'd5 : ((s == 0) ? v.a0 : v.a1);
                bv = (s >= v.k) ? 9'h107 : ((s == 0) ? v.b0 : v.b1);
                if (v.a_rowinc) av = 8'(av * (i + 1));
                if (v.b_colinc) bv = {bv[8], 8'(bv[7:0] * (i + 1))};
                a_mem[s][i*8 +: 8] = av;
                b_mem[s][i*9 +: 9] = bv;
            end
        end
    endtask

    // Start a run and observe a fixed window; n counts cycles after the start edge
    task automatic applyStimulus(input vec_t v);
        loadMem(v);
        @(negedge clk);
        K = 16'(v.k);
        B_offset = v.off;
        accumulate = v.accum;
        enable = 1'b1;
        wr_count = 0; first_wr = -1; done_n = -1; done_cnt = 0; busy_low = 0;
        busy_at_done = 1'bx;
        for (int n = 1; n <= v.k + 3 * N + 3; n++) begin
            @(negedge clk);
            if (C_wr_en) begin
                if (wr_count < N) begin
                    cap_data[wr_count] = C_data_out;
                    cap_idx[wr_count]  = C_index;
                end
                if (wr_count == 0) first_wr = n;
                wr_count++;
            end
            if (done) begin
                if (done_n < 0) done_n = n;
                done_cnt++;
            end
            if (n < v.k + 3 * N && !busy) busy_low++;
            if (n == v.k + 3 * N) busy_at_done = busy;
            enable = (v.poke != 0 && n == v.poke);
        end
        enable = 1'b0;
    endtask

    task automatic checkVector(input vec_t v, input int id);
        logic [31:0] exp;
        checkOutput($sformatf("v%0d_wr_count", id), 32'(wr_count), 32'(N));
        checkOutput($sformatf("v%0d_first_wr", id), 32'(first_wr), 32'(v.k + 2 * N));
        checkOutput($sformatf("v%0d_done_cycle", id), 32'(done_n), 32'(v.k + 3 * N));
        checkOutput($sformatf("v%0d_done_pulses", id), 32'(done_cnt), 32'd1);
        checkOutput($sformatf("v%0d_busy_drop", id), 32'(busy_low), 32'd0);
        checkOutput($sformatf("v%0d_busy_done", id), 32'(busy_at_done), 32'd0);
        for (int r = 0; r < N; r++) begin
            checkOutput($sformatf("v%0d_cidx%0d", id, r), 32'(cap_idx[r]), 32'(r));
            for (int j = 0; j < N; j++) begin
                exp = v.exp_base + v.exp_rc * 32'((r + 1) * (j + 1));
                checkOutput($sformatf("v%0d_c%0d%0d", id, r, j), cap_data[r][j*32 +: 32], exp);
            end
        end
    endtask

    // Abort a run with reset in BUSY cycle 3; nothing may be written afterwards
    task automatic resetAbort();
        vec_t v;
        int   late_wr;
        v = '{k: 4, off: 32'd0, accum: 1'b1, a0: 8'd1, a1: 8'd1, a_rowinc: 1'b0,
              b0: 9'h101, b1: 9'h101, b_colinc: 1'b0, exp_base: 32'd0, exp_rc: 32'd0, poke: 0};
        loadMem(v);
        @(negedge clk);
        K = 16'd4; B_offset = '0; accumulate = 1'b1; enable = 1'b1;
        late_wr = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            enable = 1'b0;
            if (C_wr_en) late_wr++;
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_en", 32'(C_wr_en), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (C_wr_en || done) late_wr++;
        end
        checkOutput("rst_no_write", 32'(late_wr), 32'd0);
    endtask

    initial begin
        //           k  off           acc a0     a1     rinc b0      b1      cinc base    rc  poke
        vecs[0] = '{1, 32'd0,        1'b0, 8'd1,  8'd0, 1'b1, 9'h101, 9'h000, 1'b1, 32'd0,   32'd1, 0};
        vecs[1] = '{3, 32'd128,      1'b0, 8'd2,  8'd2, 1'b0, 9'h1FF, 9'h1FF, 1'b0, 32'd762, 32'd0, 0};
        vecs[2] = '{2, 32'd0,        1'b0, 8'd3,  8'd7, 1'b0, 9'h105, 9'h005, 1'b0, 32'd15,  32'd0, 0};
        vecs[3] = '{1, 32'd0,        1'b0, 8'd1,  8'd0, 1'b0, 9'h104, 9'h000, 1'b0, 32'd4,   32'd0, 0};
        vecs[4] = '{1, 32'd0,        1'b1, 8'd1,  8'd0, 1'b0, 9'h104, 9'h000, 1'b0, 32'd8,   32'd0, 0};
        vecs[5] = '{1, 32'd0,        1'b0, 8'd1,  8'd0, 1'b0, 9'h104, 9'h000, 1'b0, 32'd4,   32'd0, 0};
        vecs[6] = '{1, 32'hFFFFFFFB, 1'b0, 8'hFD, 8'd0, 1'b0, 9'h102, 9'h000, 1'b0, 32'd9,   32'd0, 0};
        vecs[7] = '{0, 32'd0,        1'b1, 8'd0,  8'd0, 1'b0, 9'h000, 9'h000, 1'b0, 32'd9,   32'd0, 0};
        vecs[8] = '{1, 32'd0,        1'b1, 8'd2,  8'd0, 1'b0, 9'h103, 9'h000, 1'b0, 32'd6,   32'd0, 0};
        vecs[9] = '{0, 32'd0,        1'b0, 8'd0,  8'd0, 1'b0, 9'h000, 9'h000, 1'b0, 32'd0,   32'd0, 3};

        rst = 1'b1; enable = 1'b0; accumulate = 1'b0; K = '0; B_offset = '0;
        for (int s = 0; s < 16; s++) begin
            a_mem[s] = '0;
            b_mem[s] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_a_index", 32'(A_index), 32'd0);
        checkOutput("reset_c_wr_en", 32'(C_wr_en), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_c_data", 32'(|C_data_out), 32'd0);
        checkOutput("reset_busy_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        #1;
        checkOutput("reset_busy_enable", 32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (i == 8) resetAbort();
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
